seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed multi-digit 7-segment display driver.
- Latches a packed hex value, decodes one nibble per scan slot and drives shared segment lines plus per-digit enables.
- Adds blanking, decimal points, optional leading-zero suppression and tear-free update at frame boundary.
- Sits between the CPU's memory-mapped display register and the board's 7-segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1 = segments/dp driven low-true
AN_ACTIVE_LOW, 1, 1 = digit enables driven low-true
LZ_BLANK, 0, 1 = suppress leading zeros (digit 0 never suppressed)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = scan; 0 = all digits dark
load  input  1  single-cycle strobe: capture value/dp_in/blank_in into pending regs
value  input  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0]
dp_in  input  NUM_DIGITS  decimal point per digit (1 = lit, logical)
blank_in  input  NUM_DIGITS  force digit dark (1 = dark)
seg  output  7  segments, bit6=a .. bit0=g, polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW
an  output  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
frame_done  output  1  1-cycle pulse when last digit slot ends

Behaviour:
- Reset (async, active-high): prescaler=0, digit index=0, pending/shadow regs=0, state=IDLE; seg/dp = all off (7'h7F/1 if SEG_ACTIVE_LOW else 0), an = all off, frame_done=0.
- States: IDLE, SCAN.
  - IDLE: outputs off, prescaler held 0, index held 0. enable=1 -> SCAN next cycle; shadow <= pending on that transition.
  - SCAN: enable=0 -> IDLE next cycle, outputs off that same cycle (no partial digit).
- Prescaler in SCAN counts 0..SCAN_DIV-1; tick when count==SCAN_DIV-1, then wraps to 0.
- On tick: index increments; at NUM_DIGITS-1 wraps to 0, frame_done=1 for that cycle, shadow <= pending.
- Tear-free rule: load only updates pending; displayed data changes only at frame wrap or IDLE->SCAN. load coincident with wrap: new data reaches shadow on the same edge (pending bypass).
- Output path registered: seg/dp/an reflect index one cycle after it changes (1-cycle latency from tick).
- Decode: nibble 0..F -> standard hex glyphs (0=1111110, 1=0110000, ..., A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111), then polarity applied.
- Digit dark if blank_in bit set, or LZ_BLANK=1 and index>0 and all nibbles at index..NUM_DIGITS-1 are zero. Dark digit: an still asserted for its slot, seg and dp off. dp follows dp_in even if LZ-blanked; blank_in overrides dp.
- Exactly one an bit asserted in SCAN; none in IDLE.
- NUM_DIGITS=1: index constant 0, frame_done pulses every tick.
- Reset mid-frame: immediate return to reset values; no frame_done.

Decomposition:
- Shared package seg_pkg: SEG_OFF constant, 16-entry glyph constants SEG_0..SEG_F, state enum {IDLE,SCAN}.
- One sub-module hex_seg_decode: combinational 4-bit -> 7-bit glyph (active-high), instantiated once on the muxed nibble.
- Polarity, blanking, prescaler, FSM in top.

Test Plan:
- Reset with NUM_DIGITS=4, SCAN_DIV=4, active-low: seg=7'h7F, dp=1, an=4'hF; release reset, enable=0 for 20 cycles -> outputs unchanged.
- load value=16'h12AF, enable=1 -> an cycles 1110,1101,1011,0111 each 4 clks; seg = ~glyph F,A,2,1 = 7'h38,7'h08,7'h12,7'h4F; frame_done pulses once per 16 clks.
- Mid-frame load 16'h0000 during digit 1 -> remaining digits keep 12AF glyphs; next frame shows 0 on all digits (seg=7'h01).
- LZ_BLANK=1, value=16'h0050 -> digits 3,2 seg=7'h7F with an asserted; digit 1 shows 5 (7'h24), digit 0 shows 0 (7'h01); value=0 -> only digit 0 lit.
- dp_in=4'b0100, blank_in=4'b0001 -> dp=0 only in digit-2 slot; digit 0 seg=7'h7F, dp=1.
- Assert reset during digit 2 slot -> outputs off asynchronously before next edge; after release + enable, scan restarts at digit 0 with no frame_done glitch.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment scan driver.
//   SEG_OFF      - logical (active-high) glyph with every segment dark
//   SEG_0..SEG_F - active-high hex glyphs, bit6 = a .. bit0 = g
//   state_e      - scan controller states
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/seg_scan_driver_hex_seg_decode.sv
// hex_seg_decode: combinational nibble to 7-segment glyph, active-high.
//   nibble - 4-bit hex digit
//   glyph  - segments a..g on bits 6..0, 1 = lit
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Hex glyph lookup.
    always_comb begin
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed multi-digit 7-segment display driver.
//   clk, reset         - clock, asynchronous active-high reset
//   enable             - 1 = scan digits, 0 = display dark
//   load               - strobe capturing value/dp_in/blank_in into pending regs
//   value              - packed nibbles, digit 0 in bits [3:0]
//   dp_in, blank_in    - per-digit decimal point (1 = lit) and force-dark
//   seg, dp            - shared segment/decimal-point pins (polarity per SEG_ACTIVE_LOW)
//   an                 - one-hot digit enables (polarity per AN_ACTIVE_LOW)
//   frame_done         - one-cycle pulse when the last digit slot ends
// Display data is double-buffered: load writes the pending copy, and the
// shadow copy being shown is refreshed only at frame wrap or scan start.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [6:0]            SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DP_OFF_PIN  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0]   shad_val_q, shad_val_d;
    logic [NUM_DIGITS-1:0]     shad_dp_q, shad_dp_d;
    logic [NUM_DIGITS-1:0]     shad_blank_q, shad_blank_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      frame_done_q, frame_done_d;

    logic [3:0]                nibble_s;
    logic [6:0]                glyph_s;
    logic                      sel_dp_s;
    logic                      sel_blank_s;
    logic                      upper_zero_s;
    logic [NUM_DIGITS-1:0]     onehot_s;
    logic                      dark_s;
    logic [6:0]                seg_logic_s;
    logic                      dp_logic_s;

    hex_seg_decode u_decode (
        .nibble (nibble_s),
        .glyph  (glyph_s)
    );

    // Select the current digit's shadow data and detect an all-zero upper run
    // (this digit and every more-significant one) for leading-zero blanking.
    always_comb begin
        nibble_s     = 4'h0;
        sel_dp_s     = 1'b0;
        sel_blank_s  = 1'b0;
        upper_zero_s = 1'b1;
        onehot_s     = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx_q == IDX_W'(j)) begin
                nibble_s    = shad_val_q[4*j +: 4];
                sel_dp_s    = shad_dp_q[j];
                sel_blank_s = shad_blank_q[j];
                onehot_s[j] = 1'b1;
            end else begin
                onehot_s[j] = 1'b0;
            end
            upper_zero_s = upper_zero_s &
                           ((j < int'(idx_q)) || (shad_val_q[4*j +: 4] == 4'h0));
        end
        dark_s      = sel_blank_s ||
                      ((LZ_BLANK != 0) && (idx_q != IDX_W'(0)) && upper_zero_s);
        seg_logic_s = dark_s ? SEG_OFF : glyph_s;
        // Decimal point ignores leading-zero blanking; only blank_in kills it.
        dp_logic_s  = sel_blank_s ? 1'b0 : sel_dp_s;
    end

    // Scan FSM, prescaler, digit index, buffer updates and output-pin values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        // Pending copy is always the bypass source for shadow updates, so a
        // load landing on a wrap edge is displayed in the very next frame.
        pend_val_d   = load ? value    : pend_val_q;
        pend_dp_d    = load ? dp_in    : pend_dp_q;
        pend_blank_d = load ? blank_in : pend_blank_q;
        shad_val_d   = shad_val_q;
        shad_dp_d    = shad_dp_q;
        shad_blank_d = shad_blank_q;
        frame_done_d = 1'b0;
        seg_d        = SEG_OFF_PIN;
        dp_d         = DP_OFF_PIN;
        an_d         = AN_OFF_PIN;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d      = SCAN;
                    shad_val_d   = pend_val_d;
                    shad_dp_d    = pend_dp_d;
                    shad_blank_d = pend_blank_d;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_logic_s : seg_logic_s;
                    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_logic_s  : dp_logic_s;
                    an_d  = (AN_ACTIVE_LOW != 0)  ? ~onehot_s    : onehot_s;
                    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                        cnt_d = '0;
                        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            shad_val_d   = pend_val_d;
                            shad_dp_d    = pend_dp_d;
                            shad_blank_d = pend_blank_d;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the dark display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            shad_blank_q <= '0;
            seg_q        <= SEG_OFF_PIN;
            dp_q         <= DP_OFF_PIN;
            an_q         <= AN_OFF_PIN;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            shad_val_q   <= shad_val_d;
            shad_dp_q    <= shad_dp_d;
            shad_blank_q <= shad_blank_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver.
// Two instances share stimulus: u_dut (LZ_BLANK=0) and u_lz (LZ_BLANK=1),
// both with 4 digits, 4 clocks per slot, active-low segments and enables.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;

    logic [6:0]  seg, seg_lz;
    logic        dp, dp_lz;
    logic [3:0]  an, an_lz;
    logic        frame_done, frame_done_lz;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(0)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_lz (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_in(blank_in),
        .seg(seg_lz), .dp(dp_lz), .an(an_lz), .frame_done(frame_done_lz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the chosen instance's frame_done, sampled on negedges.
    task automatic sync_frame(input bit use_lz, input string tag);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if ((use_lz ? frame_done_lz : frame_done) === 1'b1) seen = 1'b1;
        end
        chk({tag, "_sync"}, {31'd0, seen}, 32'd1);
    endtask

    // Check one full frame after the next wrap: digit k sampled mid-slot.
    task automatic frame_check(input bit use_lz, input logic [27:0] exp_seg,
                               input logic [3:0] exp_dp, input string tag);
        logic [3:0] an_exp;
        sync_frame(use_lz, tag);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 2 : 4) @(negedge clk);
            an_exp = ~(4'b0001 << k);
            chk($sformatf("%s_seg%0d", tag, k), {25'd0, (use_lz ? seg_lz : seg)}, {25'd0, exp_seg[7*k +: 7]});
            chk($sformatf("%s_dp%0d", tag, k), {31'd0, (use_lz ? dp_lz : dp)}, {31'd0, exp_dp[k]});
            chk($sformatf("%s_an%0d", tag, k), {28'd0, (use_lz ? an_lz : an)}, {28'd0, an_exp});
        end
    endtask

    initial begin
        int  n;
        bit  fd_seen;

        reset    = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_in = 4'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp",  {31'd0, dp},  32'd1);
        chk("rst_an",  {28'd0, an},  32'hF);
        chk("rst_fd",  {31'd0, frame_done}, 32'd0);

        // Disabled for 20 cycles: still dark.
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_seg", {25'd0, seg}, 32'h7F);
        chk("idle_an",  {28'd0, an},  32'hF);
        chk("idle_an_lz", {28'd0, an_lz}, 32'hF);
        chk("idle_fd",  {31'd0, frame_done}, 32'd0);

        // Basic scan of 12AF.
        value = 16'h12AF;
        load  = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
        frame_check(1'b0, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1111, "scan12af");

        // Frame period and single-cycle frame_done.
        sync_frame(1'b0, "period");
        @(negedge clk);
        chk("fd_width", {31'd0, frame_done}, 32'd0);
        n = 1;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fd_period", n, 32'd16);

        // Mid-frame load during digit 1: rest of frame keeps old data.
        sync_frame(1'b0, "midload");
        repeat (5) @(negedge clk);
        value = 16'h0000;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_seg2", {25'd0, seg}, 32'h12);
        repeat (4) @(negedge clk);
        chk("mid_seg3", {25'd0, seg}, 32'h4F);
        frame_check(1'b0, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b1111, "zeros");

        // Leading-zero suppression versus plain display.
        value = 16'h0050;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        frame_check(1'b1, {7'h7F, 7'h7F, 7'h24, 7'h01}, 4'b1111, "lz0050");
        frame_check(1'b0, {7'h01, 7'h01, 7'h24, 7'h01}, 4'b1111, "nolz0050");

        // All zero with LZ: only digit 0 lit, dp survives LZ blanking.
        value = 16'h0000;
        dp_in = 4'b0100;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        frame_check(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1011, "lz0000");

        // blank_in forces digit 0 dark and overrides its dp.
        value    = 16'h12AF;
        dp_in    = 4'b0101;
        blank_in = 4'b0001;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        frame_check(1'b0, {7'h4F, 7'h12, 7'h08, 7'h7F}, 4'b1011, "blank");

        // Dropping enable darkens the display on the next edge.
        enable = 1'b0;
        @(negedge clk);
        chk("dis_an",  {28'd0, an},  32'hF);
        chk("dis_seg", {25'd0, seg}, 32'h7F);
        chk("dis_dp",  {31'd0, dp},  32'd1);

        // Reset during the digit 2 slot.
        enable = 1'b1;
        sync_frame(1'b0, "prerst");
        repeat (9) @(negedge clk);
        chk("prerst_an", {28'd0, an}, 32'hB);
        reset = 1'b1;
        #1;
        chk("arst_seg", {25'd0, seg}, 32'h7F);
        chk("arst_an",  {28'd0, an},  32'hF);
        chk("arst_dp",  {31'd0, dp},  32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Restart: off during IDLE->SCAN cycle, digit 0 next, first
        // frame_done only after a full 16-clock frame.
        fd_seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) fd_seen = 1'b1;
            if (i == 1) chk("restart_off_an", {28'd0, an}, 32'hF);
            if (i == 2) begin
                chk("restart_an",  {28'd0, an},  32'hE);
                chk("restart_seg", {25'd0, seg}, 32'h01);
                chk("restart_dp",  {31'd0, dp},  32'd1);
            end
        end
        chk("restart_no_glitch", {31'd0, fd_seen}, 32'd0);
        @(negedge clk);
        chk("restart_fd", {31'd0, frame_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
